// File: rtl/div8_seq_pkg.sv
// Shared types and constants for the div8_seq restoring divider.
// The optional divide-by-zero shortcut is selected by DIV8_SEQ_ZERO_DETECT_EN.
package div8_seq_pkg;

  localparam int WIDTH = 8;
  localparam logic [2:0] LAST_STEP = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/div8_seq_if.sv
// Request/result bundle of div8_seq: the master issues divisions, the slave answers.
interface div8_seq_if;
  import div8_seq_pkg::*;

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             dz;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, dz
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, dz
  );

endinterface

// File: rtl/div8_seq_sub8.sv
// 8-bit subtractor with borrow-in; co is the borrow out (1 when a < b + ci).
module sub8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] s,
  output logic       co
);

  assign {co, s} = {1'b0, a} - {1'b0, b} - {8'd0, ci};

endmodule

// File: rtl/div8_seq.sv
// Sequential 8-bit unsigned restoring divider, one quotient bit per clock.
// Define DIV8_SEQ_ZERO_DETECT_EN to short-cut division by zero and raise dz.
module div8_seq
  import div8_seq_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  div8_seq_if.slave      bus
);

  state_t           state;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] d;
  logic [2:0]       cnt;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] rem_r;

  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             take;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;
  logic             accept;

  // The shifted-out r[7] is a ninth bit of the partial remainder, so the
  // trial always fits when it is set and the 8-bit wrapped difference is exact.
  assign t      = {r[WIDTH-2:0], q[WIDTH-1]};
  assign take   = r[WIDTH-1] | ~co;
  assign r_next = take ? s : t;
  assign q_next = {q[WIDTH-2:0], take};
  assign accept = bus.start && (state != RUN);

  sub8 u_sub8 (
    .a  (t),
    .b  (d),
    .ci (1'b0),
    .s  (s),
    .co (co)
  );

`ifdef DIV8_SEQ_ZERO_DETECT_EN
  logic dz_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dz_r <= 1'b0;
    end else if (accept) begin
      dz_r <= (bus.divisor == '0);
    end
  end

  assign bus.dz = dz_r;
`else
  assign bus.dz = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      q      <= '0;
      r      <= '0;
      d      <= '0;
      cnt    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      quo_r  <= '0;
      rem_r  <= '0;
    end else begin
      done_r <= 1'b0;
      if (state == RUN) begin
        r <= r_next;
        q <= q_next;
        if (cnt == LAST_STEP) begin
          state  <= DONE;
          busy_r <= 1'b0;
          done_r <= 1'b1;
          quo_r  <= q_next;
          rem_r  <= r_next;
        end else begin
          cnt <= cnt + 3'd1;
        end
      end else if (accept) begin
        q   <= bus.dividend;
        d   <= bus.divisor;
        r   <= '0;
        cnt <= '0;
`ifdef DIV8_SEQ_ZERO_DETECT_EN
        if (bus.divisor == '0) begin
          state  <= DONE;
          busy_r <= 1'b0;
          done_r <= 1'b1;
          quo_r  <= '1;
          rem_r  <= bus.dividend;
        end else begin
          state  <= RUN;
          busy_r <= 1'b1;
        end
`else
        state  <= RUN;
        busy_r <= 1'b1;
`endif
      end else begin
        state <= IDLE;
      end
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.quotient  = quo_r;
  assign bus.remainder = rem_r;

endmodule

// File: tb/tb_div8_seq.sv
// Directed bench for div8_seq: vector table plus restart, reset and divide-by-zero sequences.
module tb_div8_seq;

  typedef struct {
    int dvd;
    int dvs;
    int eq;
    int er;
  } vec_t;

`ifdef DIV8_SEQ_ZERO_DETECT_EN
  localparam int ZLAT = 0;
  localparam int ZDZ  = 1;
`else
  localparam int ZLAT = 8;
  localparam int ZDZ  = 0;
`endif

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  div8_seq_if bus ();

  div8_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Leaves the bench at the falling edge just after the accepting edge.
  task automatic applyStimulus(input int dvd, input int dvs);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 8'(dvd);
    bus.divisor  = 8'(dvs);
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  task automatic waitDone(output int lat);
    lat = 0;
    while (!bus.done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.done) lat = 99;
  endtask

  task automatic runOp(input string name, input int dvd, input int dvs,
                       input int eq, input int er, input int elat, input int edz);
    int lat;
    applyStimulus(dvd, dvs);
    waitDone(lat);
    checkOutput({name, " latency"}, lat, elat);
    checkOutput({name, " quotient"}, int'(bus.quotient), eq);
    checkOutput({name, " remainder"}, int'(bus.remainder), er);
    checkOutput({name, " dz"}, int'(bus.dz), edz);
    @(negedge clk);
    checkOutput({name, " done width"}, int'(bus.done), 0);
  endtask

  initial begin
    vec_t vecs[8];
    int   lat;
    int   spurious;

    vecs[0] = '{200,   7,  28,   4};
    vecs[1] = '{255,   1, 255,   0};
    vecs[2] = '{  5,   9,   0,   5};
    vecs[3] = '{255, 255,   1,   0};
    vecs[4] = '{255, 200,   1,  55};
    vecs[5] = '{254, 129,   1, 125};
    vecs[6] = '{  0,   5,   0,   0};
    vecs[7] = '{ 13, 128,   0,  13};

    compared     = 0;
    mismatched   = 0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    repeat (2) @(negedge clk);
    checkOutput("reset outputs",
                int'({bus.busy, bus.done, bus.dz, bus.quotient, bus.remainder}), 0);
    rst = 1'b0;

    $display("[TB] divide by zero");
    runOp("77/0", 77, 0, 255, 77, ZLAT, ZDZ);

    $display("[TB] vector table");
    foreach (vecs[i]) begin
      runOp($sformatf("%0d/%0d", vecs[i].dvd, vecs[i].dvs),
            vecs[i].dvd, vecs[i].dvs, vecs[i].eq, vecs[i].er, 8, 0);
    end

    $display("[TB] start while busy is ignored");
    applyStimulus(50, 5);
    checkOutput("busy after start", int'(bus.busy), 1);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 8'd9;
    bus.divisor  = 8'd3;
    @(negedge clk);
    bus.start    = 1'b0;
    checkOutput("quotient held in run", int'(bus.quotient), 0);
    checkOutput("remainder held in run", int'(bus.remainder), 13);
    waitDone(lat);
    checkOutput("ignored start latency", lat, 6);
    checkOutput("ignored start quotient", int'(bus.quotient), 10);
    checkOutput("ignored start remainder", int'(bus.remainder), 0);

    $display("[TB] start in done cycle");
    applyStimulus(200, 7);
    waitDone(lat);
    checkOutput("first result quotient", int'(bus.quotient), 28);
    bus.start    = 1'b1;
    bus.dividend = 8'd100;
    bus.divisor  = 8'd7;
    @(negedge clk);
    bus.start    = 1'b0;
    checkOutput("restart busy", int'(bus.busy), 1);
    checkOutput("restart quotient held", int'(bus.quotient), 28);
    waitDone(lat);
    checkOutput("restart latency", lat, 8);
    checkOutput("restart quotient", int'(bus.quotient), 14);
    checkOutput("restart remainder", int'(bus.remainder), 2);

    $display("[TB] reset mid-operation");
    applyStimulus(100, 3);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("async reset outputs",
                int'({bus.busy, bus.done, bus.dz, bus.quotient, bus.remainder}), 0);
    spurious = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done) spurious++;
    end
    checkOutput("no done under reset", spurious, 0);
    rst = 1'b0;
    runOp("100/10 after reset", 100, 10, 10, 0, 8, 0);

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
